// File: rtl/meas_osc_array.sv
// Multi-channel ring-oscillator edge counter: counts synchronized rising edges per channel over a
// programmable gate window and derives one PUF response bit per channel pair.
module meas_osc_array #(
    parameter int C_DWIDTH = 24,
    parameter int C_NCH    = 8,
    parameter int C_WWIDTH = 16,
    parameter int C_SYNC   = 2
) (
    input  logic                        I_clk,
    input  logic                        I_rst,
    input  logic [C_NCH-1:0]            I_osc,
    input  logic                        I_start,
    input  logic                        I_abort,
    input  logic                        I_cont,
    input  logic [C_WWIDTH-1:0]         I_win_len,
    output logic [C_NCH*C_DWIDTH-1:0]   O_data,
    output logic [C_NCH-1:0]            O_ovf,
    output logic [C_NCH/2-1:0]          O_resp,
    output logic [C_NCH/2-1:0]          O_tie,
    output logic                        O_valid,
    output logic                        O_busy
);
    localparam int C_NPAIR = C_NCH / 2;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS, ST_LATCH} state_t;

    state_t                      state_reg, state_next;
    logic [C_WWIDTH-1:0]         win_reg;
    logic                        clr_cnt, load_win, cnt_en, latch_en;
    logic                        valid_reg;
    logic [C_NCH*C_DWIDTH-1:0]   cnt_all;

    always_ff @(posedge I_clk) begin
        if (I_rst) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Abort overrides every transition; in IDLE it simply also blocks a start.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (I_start) state_next = ST_ARM;
            ST_ARM:   state_next = (I_win_len == '0) ? ST_LATCH : ST_MEAS;
            ST_MEAS:  if (win_reg == C_WWIDTH'(1)) state_next = ST_LATCH;
            ST_LATCH: state_next = I_cont ? ST_ARM : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (I_abort) state_next = ST_IDLE;
    end

    always_comb begin
        O_busy   = (state_reg != ST_IDLE);
        clr_cnt  = (state_reg == ST_ARM);
        load_win = (state_reg == ST_ARM);
        cnt_en   = (state_reg == ST_MEAS) && !I_abort;
        latch_en = (state_reg == ST_LATCH) && !I_abort;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst)         win_reg <= '0;
        else if (load_win) win_reg <= I_win_len;
        else if (cnt_en)   win_reg <= win_reg - C_WWIDTH'(1);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) valid_reg <= 1'b0;
        else       valid_reg <= latch_en;
    end
    assign O_valid = valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < C_NCH; gi++) begin : g_ch
            logic [C_SYNC-1:0]   sync_reg;
            logic                prev_reg;
            logic                edge_pulse;
            logic [C_DWIDTH-1:0] cnt_reg;
            logic                ovf_reg;
            logic [C_DWIDTH-1:0] data_reg;
            logic                ovf_out_reg;

            always_ff @(posedge I_clk) begin
                if (I_rst) begin
                    sync_reg <= '0;
                    prev_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[C_SYNC-2:0], I_osc[gi]};
                    prev_reg <= sync_reg[C_SYNC-1];
                end
            end
            assign edge_pulse = sync_reg[C_SYNC-1] & ~prev_reg;

            // A saturated counter holds; the flag marks an edge that could not be counted.
            always_ff @(posedge I_clk) begin
                if (I_rst || clr_cnt) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (cnt_en && edge_pulse) begin
                    if (&cnt_reg) ovf_reg <= 1'b1;
                    else          cnt_reg <= cnt_reg + C_DWIDTH'(1);
                end
            end

            always_ff @(posedge I_clk) begin
                if (I_rst) begin
                    data_reg    <= '0;
                    ovf_out_reg <= 1'b0;
                end else if (latch_en) begin
                    data_reg    <= cnt_reg;
                    ovf_out_reg <= ovf_reg;
                end
            end

            assign cnt_all[gi*C_DWIDTH +: C_DWIDTH] = cnt_reg;
            assign O_data[gi*C_DWIDTH +: C_DWIDTH]  = data_reg;
            assign O_ovf[gi]                        = ovf_out_reg;
        end

        for (gi = 0; gi < C_NPAIR; gi++) begin : g_pair
            logic [C_DWIDTH-1:0] cnt_a, cnt_b;
            logic                resp_reg, tie_reg;

            assign cnt_a = cnt_all[(2*gi)*C_DWIDTH +: C_DWIDTH];
            assign cnt_b = cnt_all[(2*gi+1)*C_DWIDTH +: C_DWIDTH];

            always_ff @(posedge I_clk) begin
                if (I_rst) begin
                    resp_reg <= 1'b0;
                    tie_reg  <= 1'b0;
                end else if (latch_en) begin
                    resp_reg <= (cnt_a > cnt_b);
                    tie_reg  <= (cnt_a == cnt_b);
                end
            end

            assign O_resp[gi] = resp_reg;
            assign O_tie[gi]  = tie_reg;
        end
    endgenerate

endmodule

// File: tb/tb_meas_osc_array.sv
// Directed bench for meas_osc_array: a default 8x24-bit instance plus a 2x4-bit instance
// that shares the control inputs and exercises counter saturation.
module tb_meas_osc_array;
    logic         clk = 1'b0;
    logic         I_rst, I_start, I_abort, I_cont;
    logic [15:0]  I_win_len;
    logic [7:0]   gen_osc = '0;
    logic [7:0]   man_osc;
    logic [7:0]   osc;
    logic [191:0] O_data;
    logic [7:0]   O_ovf;
    logic [3:0]   O_resp, O_tie;
    logic         O_valid, O_busy;
    logic [7:0]   sat_data;
    logic [1:0]   sat_ovf;
    logic [0:0]   sat_resp, sat_tie;
    logic         sat_valid, sat_busy;

    int checks = 0;
    int errors = 0;
    int per [8];
    int gen_tick = 0;
    int lat, seen;
    logic busy_low;

    assign osc = gen_osc | man_osc;

    always #5 clk = ~clk;

    meas_osc_array dut (
        .I_clk(clk), .I_rst(I_rst), .I_osc(osc), .I_start(I_start), .I_abort(I_abort),
        .I_cont(I_cont), .I_win_len(I_win_len), .O_data(O_data), .O_ovf(O_ovf),
        .O_resp(O_resp), .O_tie(O_tie), .O_valid(O_valid), .O_busy(O_busy)
    );

    meas_osc_array #(.C_DWIDTH(4), .C_NCH(2), .C_WWIDTH(16), .C_SYNC(2)) dut_sat (
        .I_clk(clk), .I_rst(I_rst), .I_osc(osc[1:0]), .I_start(I_start), .I_abort(I_abort),
        .I_cont(I_cont), .I_win_len(I_win_len), .O_data(sat_data), .O_ovf(sat_ovf),
        .O_resp(sat_resp), .O_tie(sat_tie), .O_valid(sat_valid), .O_busy(sat_busy)
    );

    // Square-wave oscillators, updated away from the sampling edge; period 0 means held low.
    initial begin
        forever begin
            @(negedge clk);
            gen_tick++;
            for (int k = 0; k < 8; k++) begin
                if (per[k] != 0) gen_osc[k] = ((gen_tick % per[k]) < (per[k] / 2));
                else             gen_osc[k] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start();
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
    endtask

    // Returns the number of rising edges after the call until O_valid is seen, or -1 on timeout.
    task automatic wait_valid(input int budget, output int l);
        l = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (!O_busy) busy_low = 1'b1;
            if (O_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic count_valid(input int n, output int s);
        s = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (O_valid) s++;
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) per[k] = 0;
        man_osc = '0;
        I_rst = 1'b1; I_start = 1'b0; I_abort = 1'b0; I_cont = 1'b0; I_win_len = '0;
        busy_low = 1'b0;
        repeat (3) tick();
        chk("rst_data", O_data, 192'd0);
        chk("rst_flags", {O_ovf, O_resp, O_tie, O_valid, O_busy}, 18'd0);
        I_rst = 1'b0;
        tick();

        // Count accuracy: ch0 period 4, ch1 period 10, W=100.
        per[0] = 4; per[1] = 10; I_win_len = 16'd100;
        repeat (20) tick();
        pulse_start();
        wait_valid(300, lat);
        $display("txn count W=100 lat=%0d ch0=%0d ch1=%0d", lat, O_data[23:0], O_data[47:24]);
        chk("lat_w100", lat, 102);
        chk_rng("cnt_ch0", int'(O_data[23:0]), 24, 26);
        chk_rng("cnt_ch1", int'(O_data[47:24]), 9, 11);
        chk("cnt_idle_ch", O_data[191:48], 144'd0);
        chk("cnt_resp", O_resp, 4'b0001);
        chk("cnt_tie", O_tie, 4'b1110);
        chk("cnt_ovf", O_ovf, 8'd0);
        tick();
        chk("valid_one_cycle", O_valid, 1'b0);

        // Reset held 3 cycles in the middle of MEAS.
        I_win_len = 16'd50;
        pulse_start();
        repeat (20) tick();
        I_rst = 1'b1;
        count_valid(3, seen);
        I_rst = 1'b0;
        $display("txn reset mid-MEAS valids=%0d busy=%0b", seen, O_busy);
        chk("rst_mid_valid", seen, 0);
        chk("rst_mid_data", O_data, 192'd0);
        chk("rst_mid_flags", {O_ovf, O_resp, O_tie, O_busy}, 17'd0);
        per[0] = 0; per[1] = 0;
        repeat (10) tick();

        // Silent oscillators, W=10.
        I_win_len = 16'd10;
        pulse_start();
        wait_valid(100, lat);
        $display("txn zero W=10 lat=%0d tie=%b", lat, O_tie);
        chk("lat_w10", lat, 12);
        chk("zero_data", O_data, 192'd0);
        chk("zero_resp", O_resp, 4'b0000);
        chk("zero_tie", O_tie, 4'b1111);

        // Saturation on the 4-bit instance: ch0 ~50 edges, ch1 exactly 3.
        per[0] = 4; I_win_len = 16'd200;
        repeat (10) tick();
        pulse_start();
        repeat (20) tick();
        repeat (3) begin
            man_osc[1] = 1'b1;
            repeat (3) tick();
            man_osc[1] = 1'b0;
            repeat (3) tick();
        end
        wait_valid(400, lat);
        $display("txn sat W=200 lat=%0d sat=%h ovf=%b", lat + 38, sat_data, sat_ovf);
        chk("lat_w200", lat + 38, 202);
        chk("sat_ch0", sat_data[3:0], 4'd15);
        chk("sat_ch1", sat_data[7:4], 4'd3);
        chk("sat_ovf", sat_ovf, 2'b01);
        chk("sat_resp_tie", {sat_resp, sat_tie}, 2'b10);
        chk("sat_main_ch1", O_data[47:24], 24'd3);
        chk("sat_main_ovf", O_ovf, 8'd0);

        // Abort mid-MEAS keeps the previous result.
        I_win_len = 16'd30;
        pulse_start();
        repeat (10) tick();
        I_abort = 1'b1;
        tick();
        I_abort = 1'b0;
        chk("abort_busy", O_busy, 1'b0);
        count_valid(40, seen);
        $display("txn abort valids=%0d sat=%h", seen, sat_data);
        chk("abort_valid", seen, 0);
        chk("abort_keep_sat", {sat_data, sat_ovf}, 10'h0FD);
        chk("abort_keep_main", {O_data[47:24], O_resp}, 28'h0000031);

        // Abort together with start in IDLE: stays IDLE.
        I_start = 1'b1; I_abort = 1'b1;
        tick();
        I_start = 1'b0; I_abort = 1'b0;
        $display("txn abort+start busy=%0b", O_busy);
        chk("abort_start_idle", O_busy, 1'b0);

        // A second start during MEAS is ignored.
        per[0] = 0;
        repeat (10) tick();
        pulse_start();
        repeat (10) tick();
        I_start = 1'b1;
        tick();
        I_start = 1'b0;
        wait_valid(200, lat);
        $display("txn restart-ignored lat=%0d", lat + 11);
        chk("lat_restart", lat + 11, 32);
        chk("restart_data", O_data, 192'd0);

        // Zero-length window.
        I_win_len = 16'd0;
        pulse_start();
        wait_valid(20, lat);
        $display("txn W=0 lat=%0d", lat);
        chk("lat_w0", lat, 2);
        chk("w0_result", {O_data, O_ovf, O_resp, O_tie}, {192'd0, 8'd0, 4'd0, 4'hF});

        // Continuous mode; window change takes effect at the next ARM.
        I_cont = 1'b1; I_win_len = 16'd20;
        pulse_start();
        repeat (5) tick();
        I_win_len = 16'd40;
        busy_low = 1'b0;
        wait_valid(100, lat);
        $display("txn cont first lat=%0d", lat + 5);
        chk("cont_first", lat + 5, 22);
        wait_valid(100, lat);
        $display("txn cont second gap=%0d", lat);
        chk("cont_second", lat, 42);
        chk("cont_busy", busy_low, 1'b0);
        I_cont = 1'b0; I_abort = 1'b1;
        tick();
        I_abort = 1'b0;
        chk("cont_stop", O_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
